// File: rtl/decode_operand_unit_pkg.sv
// decode_operand_unit_pkg: instruction field bit ranges and default widths for the decode stage
package decode_operand_unit_pkg;
    localparam int DEF_NB_DATA = 32;
    localparam int DEF_NB_REG  = 5;
    localparam int DEF_NB_INM  = 16;
    localparam int OP_CODE_HI  = 31;
    localparam int OP_CODE_LO  = 26;
    localparam int RS_HI       = 25;
    localparam int RS_LO       = 21;
    localparam int RT_HI       = 20;
    localparam int RT_LO       = 16;
    localparam int RD_HI       = 15;
    localparam int RD_LO       = 11;
    localparam int SHAMT_HI    = 10;
    localparam int SHAMT_LO    = 6;
    localparam int FUNC_HI     = 5;
    localparam int FUNC_LO     = 0;
    localparam int INM_HI      = 15;
    localparam int INM_LO      = 0;
endpackage

// File: rtl/decode_operand_unit_mux2.sv
// mux2: generic two-input multiplexer, select low passes i_A
module mux2 #(
    parameter int NB_DATA = 32
) (
    input  logic [NB_DATA-1:0] i_A,
    input  logic [NB_DATA-1:0] i_B,
    input  logic               i_SEL,
    output logic [NB_DATA-1:0] o_OUT
);
    assign o_OUT = i_SEL ? i_B : i_A;
endmodule

// File: rtl/decode_operand_unit.sv
// decode_operand_unit: register file with write-through bypass, branch forwarding and immediate sign extension
module decode_operand_unit
    import decode_operand_unit_pkg::*;
#(
    parameter int NB_DATA = DEF_NB_DATA,
    parameter int NB_REG  = DEF_NB_REG,
    parameter int NB_INM  = DEF_NB_INM
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_instruction,
    input  logic               i_ctrl_read_debug_reg,
    input  logic [NB_REG-1:0]  i_addr_debug_unit,
    input  logic               i_reg_write,
    input  logic [NB_REG-1:0]  i_write_register,
    input  logic [NB_DATA-1:0] i_data_rw,
    input  logic               i_forward_A,
    input  logic               i_forward_B,
    input  logic [NB_DATA-1:0] i_data_forward_EX_MEM,
    output logic [NB_DATA-1:0] o_data_ra,
    output logic [NB_DATA-1:0] o_data_rb,
    output logic [NB_DATA-1:0] o_data_ra_branch,
    output logic [NB_DATA-1:0] o_data_rb_branch,
    output logic [NB_DATA-1:0] o_data_reg_debug_unit,
    output logic [NB_DATA-1:0] o_inm_ext
);
    logic [NB_DATA-1:0] regs [2**NB_REG] = '{default: '0};
    logic [NB_REG-1:0]  addr_a;
    logic [NB_REG-1:0]  addr_b;
    logic               unused_op_code;

    assign addr_b         = i_instruction[RT_HI:RT_LO];
    assign unused_op_code = ^i_instruction[OP_CODE_HI:OP_CODE_LO];

    mux2 #(.NB_DATA(NB_REG)) u_mux_addr_a (
        .i_A   (i_instruction[RS_HI:RS_LO]),
        .i_B   (i_addr_debug_unit),
        .i_SEL (i_ctrl_read_debug_reg),
        .o_OUT (addr_a)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset)
            regs <= '{default: '0};
        else if (i_reg_write && i_write_register != '0)
            regs[i_write_register] <= i_data_rw;
    end

    // Same-cycle bypass lets a consumer see a value written back this cycle
    always_comb begin
        o_data_ra = (addr_a == '0) ? '0 :
                    (i_reg_write && addr_a == i_write_register) ? i_data_rw : regs[addr_a];
        o_data_rb = (addr_b == '0) ? '0 :
                    (i_reg_write && addr_b == i_write_register) ? i_data_rw : regs[addr_b];
    end

    assign o_data_reg_debug_unit = o_data_ra;
    assign o_inm_ext = {{(NB_DATA-NB_INM){i_instruction[NB_INM-1]}}, i_instruction[NB_INM-1:0]};

    mux2 #(.NB_DATA(NB_DATA)) u_mux_fwd_a (
        .i_A   (o_data_ra),
        .i_B   (i_data_forward_EX_MEM),
        .i_SEL (i_forward_A),
        .o_OUT (o_data_ra_branch)
    );

    mux2 #(.NB_DATA(NB_DATA)) u_mux_fwd_b (
        .i_A   (o_data_rb),
        .i_B   (i_data_forward_EX_MEM),
        .i_SEL (i_forward_B),
        .o_OUT (o_data_rb_branch)
    );
endmodule

// File: tb/tb_decode_operand_unit.sv
// tb_decode_operand_unit: directed self-checking bench for the decode operand unit
module tb_decode_operand_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instruction = '0;
    logic        ctrl_dbg = 1'b0;
    logic [4:0]  addr_dbg = '0;
    logic        reg_write = 1'b0;
    logic [4:0]  write_register = '0;
    logic [31:0] data_rw = '0;
    logic        fwd_a = 1'b0;
    logic        fwd_b = 1'b0;
    logic [31:0] data_fwd = '0;
    logic [31:0] data_ra, data_rb, ra_branch, rb_branch, reg_dbg, inm_ext;
    int          n_cmp = 0;
    int          n_err = 0;

    decode_operand_unit dut (
        .i_clock               (clock),
        .i_reset               (reset),
        .i_instruction         (instruction),
        .i_ctrl_read_debug_reg (ctrl_dbg),
        .i_addr_debug_unit     (addr_dbg),
        .i_reg_write           (reg_write),
        .i_write_register      (write_register),
        .i_data_rw             (data_rw),
        .i_forward_A           (fwd_a),
        .i_forward_B           (fwd_b),
        .i_data_forward_EX_MEM (data_fwd),
        .o_data_ra             (data_ra),
        .o_data_rb             (data_rb),
        .o_data_ra_branch      (ra_branch),
        .o_data_rb_branch      (rb_branch),
        .o_data_reg_debug_unit (reg_dbg),
        .o_inm_ext             (inm_ext)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] make_instr(input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [15:0] inm);
        return {6'b000000, rs, rt, inm};
    endfunction

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clock);
        reg_write = 1'b1;
        write_register = addr;
        data_rw = data;
        @(negedge clock);
        reg_write = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        ctrl_dbg = 1'b1;
        for (int i = 0; i < 32; i++) begin
            addr_dbg = 5'(i);
            #1;
            n_cmp++;
            if (reg_dbg !== 32'h0) begin
                n_err++;
                $display("FAIL reset_read r%0d: got %h expected %h", i, reg_dbg, 32'h0);
            end
        end
        ctrl_dbg = 1'b0;
    endtask

    task automatic test_write_read();
        write_reg(5'd5, 32'hDEADBEEF);
        instruction = make_instr(5'd5, 5'd5, 16'h0);
        #1;
        n_cmp++;
        if (data_ra !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL r5_port_a: got %h expected %h", data_ra, 32'hDEADBEEF);
        end
        n_cmp++;
        if (data_rb !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL r5_port_b: got %h expected %h", data_rb, 32'hDEADBEEF);
        end
        n_cmp++;
        if (reg_dbg !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL r5_debug_out: got %h expected %h", reg_dbg, 32'hDEADBEEF);
        end
    endtask

    task automatic test_r0();
        @(negedge clock);
        instruction = make_instr(5'd0, 5'd0, 16'h0);
        reg_write = 1'b1;
        write_register = 5'd0;
        data_rw = 32'h12345678;
        #1;
        n_cmp++;
        if (data_rb !== 32'h0) begin
            n_err++;
            $display("FAIL r0_no_bypass: got %h expected %h", data_rb, 32'h0);
        end
        @(negedge clock);
        reg_write = 1'b0;
        #1;
        n_cmp++;
        if (data_ra !== 32'h0) begin
            n_err++;
            $display("FAIL r0_after_write: got %h expected %h", data_ra, 32'h0);
        end
    endtask

    task automatic test_bypass();
        @(negedge clock);
        instruction = make_instr(5'd5, 5'd7, 16'h0);
        reg_write = 1'b1;
        write_register = 5'd7;
        data_rw = 32'hA5A5A5A5;
        #1;
        n_cmp++;
        if (data_rb !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL bypass_port_b: got %h expected %h", data_rb, 32'hA5A5A5A5);
        end
        n_cmp++;
        if (data_ra !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL bypass_other_port_a: got %h expected %h", data_ra, 32'hDEADBEEF);
        end
        instruction = make_instr(5'd7, 5'd5, 16'h0);
        #1;
        n_cmp++;
        if (data_ra !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL bypass_port_a: got %h expected %h", data_ra, 32'hA5A5A5A5);
        end
        @(negedge clock);
        reg_write = 1'b0;
        data_rw = 32'h0;
        #1;
        n_cmp++;
        if (data_ra !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL r7_stored: got %h expected %h", data_ra, 32'hA5A5A5A5);
        end
    endtask

    task automatic test_inm();
        logic [15:0] inm_in [4]  = '{16'h8001, 16'h7FFF, 16'h0000, 16'hFFFF};
        logic [31:0] inm_exp [4] = '{32'hFFFF8001, 32'h00007FFF, 32'h00000000, 32'hFFFFFFFF};
        for (int i = 0; i < 4; i++) begin
            instruction = make_instr(5'd1, 5'd2, inm_in[i]);
            #1;
            n_cmp++;
            if (inm_ext !== inm_exp[i]) begin
                n_err++;
                $display("FAIL inm_ext %h: got %h expected %h", inm_in[i], inm_ext, inm_exp[i]);
            end
        end
    endtask

    task automatic test_forward();
        write_reg(5'd3, 32'h11);
        write_reg(5'd4, 32'h22);
        data_fwd = 32'h99;
        instruction = make_instr(5'd3, 5'd4, 16'h0);
        fwd_a = 1'b0;
        fwd_b = 1'b0;
        #1;
        n_cmp++;
        if (ra_branch !== 32'h11) begin
            n_err++;
            $display("FAIL fwd_a_off: got %h expected %h", ra_branch, 32'h11);
        end
        n_cmp++;
        if (rb_branch !== 32'h22) begin
            n_err++;
            $display("FAIL fwd_b_off: got %h expected %h", rb_branch, 32'h22);
        end
        fwd_a = 1'b1;
        #1;
        n_cmp++;
        if (ra_branch !== 32'h99 || data_ra !== 32'h11) begin
            n_err++;
            $display("FAIL fwd_a_on: got %h/%h expected %h/%h", ra_branch, data_ra, 32'h99, 32'h11);
        end
        n_cmp++;
        if (rb_branch !== 32'h22) begin
            n_err++;
            $display("FAIL fwd_b_isolated: got %h expected %h", rb_branch, 32'h22);
        end
        fwd_a = 1'b0;
        fwd_b = 1'b1;
        #1;
        n_cmp++;
        if (rb_branch !== 32'h99 || data_rb !== 32'h22) begin
            n_err++;
            $display("FAIL fwd_b_on: got %h/%h expected %h/%h", rb_branch, data_rb, 32'h99, 32'h22);
        end
        n_cmp++;
        if (ra_branch !== 32'h11) begin
            n_err++;
            $display("FAIL fwd_a_isolated: got %h expected %h", ra_branch, 32'h11);
        end
        fwd_b = 1'b0;
        ctrl_dbg = 1'b1;
        addr_dbg = 5'd5;
        #1;
        n_cmp++;
        if (data_ra !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL debug_overrides_rs: got %h expected %h", data_ra, 32'hDEADBEEF);
        end
        ctrl_dbg = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4] = '{32'h10101010, 32'h20202020, 32'h30303030, 32'h40404040};
        @(negedge clock);
        reg_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            write_register = 5'(10 + i);
            data_rw = vals[i];
            @(negedge clock);
        end
        reg_write = 1'b0;
        ctrl_dbg = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr_dbg = 5'(10 + i);
            #1;
            n_cmp++;
            if (reg_dbg !== vals[i]) begin
                n_err++;
                $display("FAIL b2b r%0d: got %h expected %h", 10 + i, reg_dbg, vals[i]);
            end
        end
        ctrl_dbg = 1'b0;
    endtask

    task automatic test_reset_write();
        @(negedge clock);
        reset = 1'b1;
        reg_write = 1'b1;
        write_register = 5'd9;
        data_rw = 32'hCAFEF00D;
        @(negedge clock);
        reset = 1'b0;
        reg_write = 1'b0;
        ctrl_dbg = 1'b1;
        addr_dbg = 5'd9;
        #1;
        n_cmp++;
        if (reg_dbg !== 32'h0) begin
            n_err++;
            $display("FAIL reset_write_r9: got %h expected %h", reg_dbg, 32'h0);
        end
        addr_dbg = 5'd5;
        #1;
        n_cmp++;
        if (reg_dbg !== 32'h0) begin
            n_err++;
            $display("FAIL reset_clears_r5: got %h expected %h", reg_dbg, 32'h0);
        end
        ctrl_dbg = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_r0();
        test_bypass();
        test_inm();
        test_forward();
        test_back_to_back();
        test_reset_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/decode_operand_unit.md
DECODE_OPERAND_UNIT -- requirements
Module: decode_operand_unit

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32, register and data width.
REQ-002 The block SHALL have parameter NB_REG, default 5, register-address width (2^NB_REG registers).
REQ-003 The block SHALL have parameter NB_INM, default 16, immediate field width.
REQ-004 The block SHALL have port i_clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port i_instruction, input, NB_DATA bits: fetched instruction; rs=[25:21], rt=[20:16], immediate=[15:0].
REQ-007 The block SHALL have port i_ctrl_read_debug_reg, input, 1 bit: 1 selects the debug address for read port A.
REQ-008 The block SHALL have port i_addr_debug_unit, input, NB_REG bits: debug register address.
REQ-009 The block SHALL have port i_reg_write, input, 1 bit: write enable.
REQ-010 The block SHALL have port i_write_register, input, NB_REG bits: write address.
REQ-011 The block SHALL have port i_data_rw, input, NB_DATA bits: write data.
REQ-012 The block SHALL have ports i_forward_A and i_forward_B, input, 1 bit each: forwarding selects.
REQ-013 The block SHALL have port i_data_forward_EX_MEM, input, NB_DATA bits: forwarded value.
REQ-014 The block SHALL have ports o_data_ra and o_data_rb, output, NB_DATA bits each: raw register-file reads.
REQ-015 The block SHALL have ports o_data_ra_branch and o_data_rb_branch, output, NB_DATA bits each: forwarded operands for branch compare.
REQ-016 The block SHALL have port o_data_reg_debug_unit, output, NB_DATA bits: equals o_data_ra.
REQ-017 The block SHALL have port o_inm_ext, output, NB_DATA bits: sign-extended immediate.

Function
REQ-018 The register file SHALL hold 2^NB_REG registers of NB_DATA bits with two combinational read ports and one write port.
REQ-019 Read port A address SHALL be i_addr_debug_unit when i_ctrl_read_debug_reg=1, otherwise i_instruction[25:21].
REQ-020 Read port B address SHALL be i_instruction[20:16].
REQ-021 When i_reg_write=1 and i_reset=0, the register at i_write_register SHALL take i_data_rw at the rising edge.
REQ-022 Register 0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-023 A read whose address equals i_write_register while i_reg_write=1 (address nonzero) SHALL return i_data_rw in the same cycle (write-through bypass), on either port.
REQ-024 o_data_ra_branch SHALL be i_data_forward_EX_MEM when i_forward_A=1, otherwise o_data_ra; o_data_rb_branch SHALL behave the same using i_forward_B and o_data_rb.
REQ-025 o_inm_ext SHALL be i_instruction[15:0] with bit 15 replicated into bits [31:16]; the path is purely combinational.
REQ-026 All outputs SHALL be combinational functions of the current inputs and register contents; there is no added latency.

Reset
REQ-027 While i_reset=1 at a rising edge, all registers SHALL clear to 0, and any write that cycle SHALL be suppressed.
REQ-028 After reset, every read SHALL return 0 until written; the combinational outputs need no reset value.
REQ-029 At time zero, simulation SHALL initialise all registers to 0.

Structure
REQ-030 A shared package SHALL hold the instruction field bit ranges (RS, RT, RD, SHAMT, FUNC, INM, OP_CODE) and the default widths.
REQ-031 The block SHALL instantiate one generic sub-module, mux2 (parameter NB_DATA; i_A, i_B, i_SEL, o_OUT; SEL=0 gives A), three times: debug-address select, forward A, forward B.
REQ-032 The register array and the sign-extension logic SHALL be coded inline.

Verification
REQ-033 Reset, then read all 32 addresses via the debug port -> every read returns 0x00000000.
REQ-034 Write 0xDEADBEEF to r5, then set instruction rs=5, rt=5 -> o_data_ra = o_data_rb = 0xDEADBEEF; write 0x12345678 to r0 -> r0 still reads 0.
REQ-035 In the same cycle, i_reg_write=1, addr 7, data 0xA5A5A5A5, with rt=7 -> o_data_rb = 0xA5A5A5A5 before the edge.
REQ-036 Immediate 0x8001 -> o_inm_ext = 0xFFFF8001; immediate 0x7FFF -> o_inm_ext = 0x00007FFF.
REQ-037 With r3=0x11, forward value 0x99, rs=3: i_forward_A=0 -> o_data_ra_branch=0x11; i_forward_A=1 -> 0x99 while o_data_ra stays 0x11; repeat for port B.
REQ-038 Assert i_reset together with a write to r9 -> r9 reads 0 afterwards.
